// File: rtl/snitch_tb_clint_pkg.sv
// snitch_tb_clint_pkg: register offsets, types and byte-merge helper shared by the CLINT files.
package snitch_tb_clint_pkg;
  localparam logic [15:0] MsipBase     = 16'h0000;
  localparam logic [15:0] MtimecmpBase = 16'h4000;
  localparam logic [15:0] MtimeLo      = 16'hBFF8;
  localparam logic [15:0] MtimeHi      = 16'hBFFC;
  typedef logic [63:0] mtime_t;
  typedef enum logic {Idle, Resp} state_e;
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wdata,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? wdata[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/snitch_tb_clint_timer.sv
// snitch_tb_clint_timer: 64-bit mtime counter with software word overrides.
// Define SNITCH_TB_CLINT_RTC_SYNC_EN to treat rtc_i as an asynchronous clock (sync + edge detect).
module snitch_tb_clint_timer
  import snitch_tb_clint_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rtc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output mtime_t      mtime_o
);
  mtime_t mtime_q, mtime_d;
  logic   tick;
`ifdef SNITCH_TB_CLINT_RTC_SYNC_EN
  logic [2:0] rtc_q, rtc_d;
  assign rtc_d = {rtc_q[1:0], rtc_i};
  assign tick  = rtc_q[1] & ~rtc_q[2];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rtc_q <= '0;
    else         rtc_q <= rtc_d;
  end
`else
  assign tick = rtc_i;
`endif
  // A software write suppresses the tick for both words; only written bytes change.
  always_comb begin
    mtime_d = (wr_lo_i | wr_hi_i)
      ? {wr_hi_i ? be_merge(mtime_q[63:32], wdata_i, be_i) : mtime_q[63:32],
         wr_lo_i ? be_merge(mtime_q[31:0],  wdata_i, be_i) : mtime_q[31:0]}
      : mtime_q + mtime_t'(tick);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mtime_q <= '0;
    else         mtime_q <= mtime_d;
  end
  assign mtime_o = mtime_q;
endmodule

// File: rtl/snitch_tb_clint.sv
// snitch_tb_clint: core-local interruptor (msip, mtimecmp, mtime) behind a 32-bit req/rsp port.
// Optional macro SNITCH_TB_CLINT_RTC_SYNC_EN selects a synchronized, edge-detected rtc_i.
module snitch_tb_clint
  import snitch_tb_clint_pkg::*;
#(
  parameter int unsigned NrCores         = 8,
  parameter int unsigned AddrWidth       = 16,
  parameter logic [31:0] MtimeCmpResetHi = 32'hFFFF_FFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rtc_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [NrCores-1:0]   msip_o,
  output logic [NrCores-1:0]   mtip_o
);
  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr;
  logic                 accept, wr, hit, time_lo_hit, time_hi_hit;
  logic [NrCores-1:0]   msip_hit, cmp_lo_hit, cmp_hi_hit;
  logic [NrCores-1:0]   msip_q, msip_d, mtip_q, mtip_d;
  mtime_t               mtimecmp_q [NrCores];
  mtime_t               mtimecmp_d [NrCores];
  mtime_t               mtime;
  logic [31:0]          rdata, rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_error_q, rsp_error_d;

  assign addr        = req_addr_i & ~AddrWidth'(3);
  assign accept      = (state_q == Idle) & req_valid_i;
  assign wr          = accept & req_write_i;
  assign time_lo_hit = addr == AddrWidth'(MtimeLo);
  assign time_hi_hit = addr == AddrWidth'(MtimeHi);

  always_comb begin
    rdata = time_lo_hit ? mtime[31:0] : time_hi_hit ? mtime[63:32] : 32'b0;
    for (int i = 0; i < NrCores; i++) begin
      msip_hit[i]   = addr == AddrWidth'(int'(MsipBase) + 4*i);
      cmp_lo_hit[i] = addr == AddrWidth'(int'(MtimecmpBase) + 8*i);
      cmp_hi_hit[i] = addr == AddrWidth'(int'(MtimecmpBase) + 8*i + 4);
      rdata |= msip_hit[i] ? {31'b0, msip_q[i]} :
               cmp_lo_hit[i] ? mtimecmp_q[i][31:0] :
               cmp_hi_hit[i] ? mtimecmp_q[i][63:32] : 32'b0;
      msip_d[i] = (wr & msip_hit[i] & req_be_i[0]) ? req_wdata_i[0] : msip_q[i];
      mtimecmp_d[i] = {
        (wr & cmp_hi_hit[i]) ? be_merge(mtimecmp_q[i][63:32], req_wdata_i, req_be_i) : mtimecmp_q[i][63:32],
        (wr & cmp_lo_hit[i]) ? be_merge(mtimecmp_q[i][31:0],  req_wdata_i, req_be_i) : mtimecmp_q[i][31:0]};
      mtip_d[i] = mtime >= mtimecmp_q[i];
    end
    hit         = |{msip_hit, cmp_lo_hit, cmp_hi_hit, time_lo_hit, time_hi_hit};
    state_d     = accept ? Resp : (state_q == Resp && rsp_ready_i) ? Idle : state_q;
    rsp_rdata_d = accept ? ((req_write_i | ~hit) ? 32'b0 : rdata) : rsp_rdata_q;
    rsp_error_d = accept ? ~hit : rsp_error_q;
  end

  snitch_tb_clint_timer i_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rtc_i   (rtc_i),
    .wr_lo_i (wr & time_lo_hit),
    .wr_hi_i (wr & time_hi_hit),
    .wdata_i (req_wdata_i),
    .be_i    (req_be_i),
    .mtime_o (mtime)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      msip_q      <= '0;
      mtip_q      <= '0;
      for (int i = 0; i < NrCores; i++) mtimecmp_q[i] <= {MtimeCmpResetHi, 32'hFFFF_FFFF};
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      msip_q      <= msip_d;
      mtip_q      <= mtip_d;
      for (int i = 0; i < NrCores; i++) mtimecmp_q[i] <= mtimecmp_d[i];
    end
  end

  assign req_ready_o = state_q == Idle;
  assign rsp_valid_o = state_q == Resp;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign msip_o      = msip_q;
  assign mtip_o      = mtip_q;
endmodule

// File: tb/tb_snitch_tb_clint.sv
// tb_snitch_tb_clint: directed scoreboard bench for snitch_tb_clint (rtc_i as synchronous enable).
module tb_snitch_tb_clint;
  logic        clk = 0, rst_n = 0, rtc = 0;
  logic        req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [15:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic [3:0]  req_be = 0;
  logic        req_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [7:0]  msip, mtip;
  int          checks = 0, errors = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  snitch_tb_clint dut (
    .clk_i(clk), .rst_ni(rst_n), .rtc_i(rtc),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error), .msip_o(msip), .mtip_o(mtip)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xact(input string tag, input logic [15:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e,
                      input int stall, input logic tick);
    int n;
    sb_q.push_back({exp_e, exp_d});
    @(negedge clk);
    chk({tag, " ready"}, 64'(req_ready), 64'(1));
    req_valid = 1; req_addr = a; req_write = w; req_wdata = wd; req_be = be; rtc = tick;
    @(posedge clk);
    #1 req_valid = 0; rtc = 0;
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    chk({tag, " latency"}, 64'(n), 64'(0));
    for (int s = 0; s < stall; s++) begin
      chk({tag, " stall valid"}, 64'(rsp_valid), 64'(1));
      chk({tag, " stall ready"}, 64'(req_ready), 64'(0));
      chk({tag, " stall data"}, 64'({rsp_error, rsp_rdata}), 64'(sb_q[0]));
      @(negedge clk);
    end
    chk(tag, 64'({rsp_error, rsp_rdata}), 64'(sb_q.pop_front()));
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst ready", 64'(req_ready), 64'(1));
    chk("rst rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst rdata", 64'(rsp_rdata), 64'(0));
    chk("rst error", 64'(rsp_error), 64'(0));
    chk("rst msip", 64'(msip), 64'(0));
    chk("rst mtip", 64'(mtip), 64'(0));
    rst_n = 1;
    xact("mtime lo rst", 16'hBFF8, 0, 0, 4'h0, 32'h0, 0, 0, 0);
    xact("cmp0 lo rst", 16'h4000, 0, 0, 4'h0, 32'hFFFF_FFFF, 0, 0, 0);
    xact("cmp0 hi rst", 16'h4004, 0, 0, 4'h0, 32'hFFFF_FFFF, 0, 0, 0);
    // msip writes and byte enables
    xact("msip1 wr", 16'h0004, 1, 32'h1, 4'hF, 32'h0, 0, 0, 0);
    chk("msip after wr", 64'(msip), 64'(8'h02));
    xact("msip1 rd", 16'h0004, 0, 0, 4'h0, 32'h1, 0, 0, 0);
    xact("msip0 wr ones", 16'h0000, 1, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, 0, 0);
    xact("msip0 rd", 16'h0000, 0, 0, 4'h0, 32'h1, 0, 0, 0);
    xact("msip1 clr", 16'h0004, 1, 32'h0, 4'hF, 32'h0, 0, 0, 0);
    chk("msip after clr", 64'(msip), 64'(8'h01));
    xact("msip0 wr be0", 16'h0000, 1, 32'h0, 4'h0, 32'h0, 0, 0, 0);
    xact("msip0 rd be0", 16'h0000, 0, 0, 4'h0, 32'h1, 0, 0, 0);
    xact("cmp1 lo be", 16'h4008, 1, 32'h1234_ABCD, 4'b0011, 32'h0, 0, 0, 0);
    xact("cmp1 lo rd", 16'h4008, 0, 0, 4'h0, 32'hFFFF_ABCD, 0, 0, 0);
    // timer compare: mtime counts from 0 while rtc is high
    xact("cmp0 lo wr", 16'h4000, 1, 32'd100, 4'hF, 32'h0, 0, 0, 0);
    xact("cmp0 hi wr", 16'h4004, 1, 32'd0, 4'hF, 32'h0, 0, 0, 0);
    @(negedge clk);
    rtc = 1;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      chk($sformatf("mtip k=%0d", k), 64'(mtip), 64'({7'b0, (k - 1) >= 100}));
    end
    rtc = 0;
    xact("mtime lo at 110", 16'hBFF8, 0, 0, 4'h0, 32'd110, 0, 0, 0);
    // wrap
    xact("mtime lo ones", 16'hBFF8, 1, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, 0, 0);
    xact("mtime hi ones", 16'hBFFC, 1, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, 0, 0);
    @(negedge clk); rtc = 1;
    @(negedge clk); rtc = 0;
    xact("wrap lo", 16'hBFF8, 0, 0, 4'h0, 32'h0, 0, 0, 0);
    xact("wrap hi", 16'hBFFC, 0, 0, 4'h0, 32'h0, 0, 0, 0);
    chk("mtip after wrap", 64'(mtip), 64'(0));
    // write collides with tick
    xact("mtime hi set", 16'hBFFC, 1, 32'h1234_5678, 4'hF, 32'h0, 0, 0, 0);
    xact("mtime lo wr+tick", 16'hBFF8, 1, 32'd5, 4'hF, 32'h0, 0, 0, 1);
    xact("collide lo", 16'hBFF8, 0, 0, 4'h0, 32'd5, 0, 0, 0);
    xact("collide hi", 16'hBFFC, 0, 0, 4'h0, 32'h1234_5678, 0, 0, 0);
    xact("tick rd", 16'hBFF8, 0, 0, 4'h0, 32'd5, 0, 0, 1);
    xact("after tick lo", 16'hBFF8, 0, 0, 4'h0, 32'd6, 0, 0, 0);
    // errors and back-pressure
    xact("err rd 8000", 16'h8000, 0, 0, 4'h0, 32'h0, 1, 5, 0);
    xact("err wr msip8", 16'h0020, 1, 32'h1, 4'hF, 32'h0, 1, 0, 0);
    chk("msip after err", 64'(msip), 64'(8'h01));
    xact("err rd cmp8", 16'h4040, 0, 0, 4'h0, 32'h0, 1, 0, 0);
    xact("cmp7 hi rd", 16'h403C, 0, 0, 4'h0, 32'hFFFF_FFFF, 0, 0, 0);
    // asynchronous reset during a pending response
    @(negedge clk);
    req_valid = 1; req_addr = 16'h0008; req_write = 1; req_wdata = 32'h1; req_be = 4'hF;
    @(posedge clk);
    #1 req_valid = 0;
    chk("mid msip", 64'(msip), 64'(8'h05));
    chk("mid rsp_valid", 64'(rsp_valid), 64'(1));
    #2 rst_n = 0;
    #1;
    chk("arst rsp_valid", 64'(rsp_valid), 64'(0));
    chk("arst ready", 64'(req_ready), 64'(1));
    chk("arst msip", 64'(msip), 64'(0));
    @(negedge clk);
    rst_n = 1;
    xact("post rst cmp1 lo", 16'h4008, 0, 0, 4'h0, 32'hFFFF_FFFF, 0, 0, 0);
    xact("post rst mtime hi", 16'hBFFC, 0, 0, 4'h0, 32'h0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
